// File: rtl/ws_write_arbiter_pkg.sv
// Shared types for the two-port ws2812 write arbiter: FSM state, colour word and LED index.
package ws_write_arbiter_pkg;

    localparam int LED_IDX_W = 8;

    typedef logic [23:0]          rgb_t;
    typedef logic [LED_IDX_W-1:0] led_idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } arb_state_e;

    // True when the LED index addresses a pixel that physically exists on the chain.
    function automatic logic ledInRange(input led_idx_t led, input int numLeds);
        return (32'(led) < 32'(numLeds));
    endfunction

endpackage

// File: rtl/ws_write_arbiter_if.sv
// Bundle of the two requester handshakes plus the ws2812 core-side write port and status.
interface ws_write_arbiter_if;
    import ws_write_arbiter_pkg::*;

    logic        req0_valid;
    logic        req0_lock;
    led_idx_t    req0_led_num;
    rgb_t        req0_rgb;
    logic        req0_ready;

    logic        req1_valid;
    logic        req1_lock;
    led_idx_t    req1_led_num;
    rgb_t        req1_rgb;
    logic        req1_ready;

    logic        write;
    led_idx_t    led_num;
    rgb_t        rgb_data;
    logic        err;
    logic        busy;
    logic [15:0] write_count;

    modport master (
        output req0_valid, req0_lock, req0_led_num, req0_rgb,
        output req1_valid, req1_lock, req1_led_num, req1_rgb,
        input  req0_ready, req1_ready,
        input  write, led_num, rgb_data, err, busy, write_count
    );

    modport slave (
        input  req0_valid, req0_lock, req0_led_num, req0_rgb,
        input  req1_valid, req1_lock, req1_led_num, req1_rgb,
        output req0_ready, req1_ready,
        output write, led_num, rgb_data, err, busy, write_count
    );

endinterface

// File: rtl/ws_gap_timer.sv
// Post-write idle timer: loads GAP_CYCLES on a core write, counts down to zero and stays there.
module ws_gap_timer #(
    parameter int GAP_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    output logic o_zero
);

    // A zero-cycle gap still needs a one-bit counter so the zero flag stays well defined.
    localparam int CNT_W = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(GAP_CYCLES);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/ws_write_arbiter.sv
// Two-port round-robin arbiter feeding a ws2812 core, with burst locking, post-write gap
// enforcement and out-of-range index reporting.
module ws_write_arbiter
    import ws_write_arbiter_pkg::*;
#(
    parameter int NUM_LEDS   = 8,
    parameter int GAP_CYCLES = 4,
    parameter int MAX_BURST  = NUM_LEDS
) (
    input  logic              clk,
    input  logic              reset,
    ws_write_arbiter_if.slave bus
);

    localparam int BURST_W = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);

    arb_state_e         r_state;
    logic               r_owner;
    logic               r_lastServed;
    logic [BURST_W-1:0] r_burstCnt;
    logic               r_write;
    logic               r_err;
    led_idx_t           r_ledNum;
    rgb_t               r_rgb;
    logic [15:0]        r_writeCount;

    logic               w_gapZero;
    logic               w_ready0;
    logic               w_ready1;
    logic               w_acc0;
    logic               w_acc1;
    logic               w_accept;
    logic               w_selPort;
    logic               w_selLock;
    led_idx_t           w_selLed;
    rgb_t               w_selRgb;
    logic               w_ownerLock;
    logic               w_inRange;
    logic               w_issue;
    logic [BURST_W-1:0] w_burstNext;
    logic               w_burstDone;

    ws_gap_timer #(
        .GAP_CYCLES(GAP_CYCLES)
    ) u_gapTimer (
        .clk    (clk),
        .reset  (reset),
        .i_load (w_issue),
        .o_zero (w_gapZero)
    );

    // Readys depend only on state, gap and valids; contention in IDLE favours the port not served last.
    always_comb begin
        w_ready0 = 1'b0;
        w_ready1 = 1'b0;
        if (!reset && w_gapZero) begin
            if (r_state == ST_IDLE) begin
                if (bus.req0_valid && bus.req1_valid) begin
                    w_ready0 = r_lastServed;
                    w_ready1 = ~r_lastServed;
                end else begin
                    w_ready0 = bus.req0_valid;
                    w_ready1 = bus.req1_valid;
                end
            end else begin
                w_ready0 = (r_owner == 1'b0);
                w_ready1 = (r_owner == 1'b1);
            end
        end
    end

    assign w_acc0      = bus.req0_valid & w_ready0;
    assign w_acc1      = bus.req1_valid & w_ready1;
    assign w_accept    = w_acc0 | w_acc1;
    assign w_selPort   = w_acc1;
    assign w_selLock   = w_selPort ? bus.req1_lock    : bus.req0_lock;
    assign w_selLed    = w_selPort ? bus.req1_led_num : bus.req0_led_num;
    assign w_selRgb    = w_selPort ? bus.req1_rgb     : bus.req0_rgb;
    assign w_ownerLock = r_owner   ? bus.req1_lock    : bus.req0_lock;
    assign w_inRange   = ledInRange(w_selLed, NUM_LEDS);
    assign w_issue     = w_accept & w_inRange;
    assign w_burstNext = r_burstCnt + BURST_W'(1);
    assign w_burstDone = (w_burstNext == BURST_W'(MAX_BURST));

    // Out-of-range transfers still count toward the burst but never reach the core.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_lastServed <= 1'b1;
            r_burstCnt   <= '0;
            r_write      <= 1'b0;
            r_err        <= 1'b0;
            r_ledNum     <= '0;
            r_rgb        <= '0;
            r_writeCount <= '0;
        end else begin
            r_write <= w_issue;
            r_err   <= w_accept & ~w_inRange;
            if (w_issue) begin
                r_ledNum     <= w_selLed;
                r_rgb        <= w_selRgb;
                r_writeCount <= r_writeCount + 16'd1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_lastServed <= w_selPort;
                        if (w_selLock && (MAX_BURST > 1)) begin
                            r_state    <= ST_LOCKED;
                            r_owner    <= w_selPort;
                            r_burstCnt <= BURST_W'(1);
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_accept) begin
                        r_burstCnt <= w_burstNext;
                    end
                    // Owner releases by dropping lock, or loses it after a full burst.
                    if (!w_ownerLock || (w_accept && w_burstDone)) begin
                        r_state      <= ST_IDLE;
                        r_lastServed <= r_owner;
                        r_burstCnt   <= '0;
                    end
                end
            endcase
        end
    end

    assign bus.req0_ready  = w_ready0;
    assign bus.req1_ready  = w_ready1;
    assign bus.write       = r_write;
    assign bus.led_num     = r_ledNum;
    assign bus.rgb_data    = r_rgb;
    assign bus.err         = r_err;
    assign bus.write_count = r_writeCount;
    assign bus.busy        = (r_state == ST_LOCKED) | ~w_gapZero | r_write;

endmodule
